peripheral_pulse_multi: RTL

//  N-channel synchronising, debouncing edge-to-pulse generator with per-channel edge mode.

---
 rtl/peripheral_pulse_multi.sv | 108 ++++++++++
 1 files changed

// File: rtl/peripheral_pulse_multi.sv
// N-channel synchroniser + debouncer + edge-to-pulse generator with per-channel edge mode.
// Each channel produces a PULSE_LEN-cycle pulse and sticky event/missed flags.
module peripheral_pulse_multi #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned PULSE_LEN       = 4,
  parameter bit          RETRIGGER       = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   d,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   pulse,
  output logic              any_pulse,
  output logic [N_CH-1:0]   event_flag,
  output logic [N_CH-1:0]   missed
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);
  localparam logic [DW-1:0] DebMax   = DW'(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PulseMax = PW'(PULSE_LEN);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl_q, lvl_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic                   flag_q, flag_d;
    logic                   missed_q, missed_d;
    logic                   raw_evt, qual_evt, miss_set;
    logic [1:0]             ch_mode;

    assign s       = sync_q[SYNC_STAGES-1];
    assign ch_mode = mode[2*i +: 2];

    // A new level is accepted only after it has persisted DEBOUNCE_CYCLES+1 cycles at s.
    always_comb begin
      lvl_d   = lvl_q;
      dcnt_d  = '0;
      raw_evt = 1'b0;
      if (s != lvl_q) begin
        if (dcnt_q == DebMax) begin
          lvl_d   = s;
          raw_evt = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    always_comb begin
      qual_evt = 1'b0;
      case (ch_mode)
        2'b01:   qual_evt = raw_evt & s;
        2'b10:   qual_evt = raw_evt & ~s;
        2'b11:   qual_evt = raw_evt;
        default: qual_evt = 1'b0;
      endcase
    end

    always_comb begin
      pcnt_d   = pcnt_q;
      miss_set = 1'b0;
      if (pcnt_q != '0) begin
        pcnt_d = pcnt_q - 1'b1;
      end
      if (qual_evt) begin
        if ((pcnt_q == '0) || RETRIGGER) begin
          pcnt_d = PulseMax;
        end else begin
          miss_set = 1'b1;
        end
      end
      // Set has priority over a same-cycle clear.
      flag_d   = qual_evt | (flag_q & ~clr[i]);
      missed_d = miss_set | (missed_q & ~clr[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q   <= '0;
        lvl_q    <= 1'b0;
        dcnt_q   <= '0;
        pcnt_q   <= '0;
        flag_q   <= 1'b0;
        missed_q <= 1'b0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], d[i]};
        lvl_q    <= lvl_d;
        dcnt_q   <= dcnt_d;
        pcnt_q   <= pcnt_d;
        flag_q   <= flag_d;
        missed_q <= missed_d;
      end
    end

    assign pulse[i]      = (pcnt_q != '0);
    assign event_flag[i] = flag_q;
    assign missed[i]     = missed_q;
  end

  assign any_pulse = |pulse;

endmodule
